serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor: it accepts a WIDTH-bit minuend and subtrahend through a valid/ready handshake, then processes one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It returns the WIDTH-bit difference and the final borrow on a second valid/ready handshake. It is the subtracting counterpart of the team's ripple-add datapath, used wherever a count must be decremented or compared with minimal area (e.g. neighbour-count threshold checks).

---
 rtl/serial_arith_pkg.sv | 24 ++
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
// Adders and subtractors built on one-bit cells agree on state names and bit order here.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Operands are consumed least-significant bit first.
    localparam bit LSB_FIRST = 1'b1;

    // Bit counter wide enough to hold 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Operand bit position fed to the one-bit cell each cycle.
    function automatic int first_bit_idx(input int w);
        return LSB_FIRST ? 0 : (w - 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
// Master drives operands and result acceptance; slave returns difference, borrow and busy.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] difference;
    logic             borrow;
    logic             busy;

    modport master (
        output in_valid, minuend, subtrahend, out_ready,
        input  in_ready, out_valid, difference, borrow, busy
    );

    modport slave (
        input  in_valid, minuend, subtrahend, out_ready,
        output in_ready, out_valid, difference, borrow, busy
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - b_in, b_out set when the result underflows.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);
    assign diff  = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~a & b_in) | (b & b_in);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, registered borrow.
// Latency: result valid WIDTH cycles after the accept edge; issue interval WIDTH+2.
// Backpressure: DONE holds difference/borrow stable until out_ready; no input accepted until IDLE.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W     = cnt_width(WIDTH);
    localparam int FIRST_IDX = first_bit_idx(WIDTH);

    sub_state_t       state_q;
    sub_state_t       state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] diff_q;
    logic             brw_q;
    logic             brw_out_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cell_d;
    logic             cell_bo;
    logic             accept;
    logic             last_bit;

    full_subtractor u_cell (
        .a     (a_q[FIRST_IDX]),
        .b     (b_q[FIRST_IDX]),
        .b_in  (brw_q),
        .diff  (cell_d),
        .b_out (cell_bo)
    );

    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign last_bit = (state_q == CALC) && (cnt_q == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = (res_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = CALC;
            CALC:    if (last_bit)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            diff_q    <= '0;
            brw_q     <= 1'b0;
            brw_out_q <= 1'b0;
            cnt_q     <= '0;
        end else if (accept) begin
            a_q   <= bus.minuend;
            b_q   <= bus.subtrahend;
            res_q <= '0;
            brw_q <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == CALC) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            res_q <= res_next;
            brw_q <= cell_bo;
            cnt_q <= cnt_q + CNT_W'(1);
            // Published outputs only move here, so they survive the output handshake.
            if (last_bit) begin
                diff_q    <= res_next;
                brw_out_q <= cell_bo;
            end
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.busy       = (state_q == CALC) || (state_q == DONE);
    assign bus.difference = diff_q;
    assign bus.borrow     = brw_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] dif;
        logic       brw;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    exp_t       exp_q[$];
    logic [1:0] exp1_q[$];

    logic fs_a, fs_b, fs_bin, fs_d, fs_bo;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(1)) if1 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    full_subtractor u_fs (.a(fs_a), .b(fs_b), .b_in(fs_bin), .diff(fs_d), .b_out(fs_bo));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        exp_t       e;
        t     = {1'b0, a} - {1'b0, b};
        e.dif = t[7:0];
        e.brw = t[8];
        return e;
    endfunction

    // Drives operands, waits for acceptance, returns the cycle index of the accept edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, output int acc, output bit ok);
        ok              = 1'b0;
        acc             = -1;
        if8.in_valid    = 1'b1;
        if8.minuend     = a;
        if8.subtrahend  = b;
        for (int i = 0; i < 50; i++) begin
            if (if8.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            exp_q.push_back(model8(a, b));
            @(posedge clk);
            #1;
            acc = cyc;
        end
        if8.in_valid = 1'b0;
    endtask

    task automatic wait_out8(output int t, output bit ok);
        ok = 1'b0;
        t  = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if8.out_valid === 1'b1) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        if8.in_valid = 1'b0; if8.minuend = '0; if8.subtrahend = '0; if8.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.minuend = '0; if1.subtrahend = '0; if1.out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({if8.in_ready, if8.out_valid, if8.busy, if8.difference, if8.borrow} !== {3'b100, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_w8: rdy/vld/busy/diff/brw=%b/%b/%b/%0d/%b required 1/0/0/0/0",
                     if8.in_ready, if8.out_valid, if8.busy, if8.difference, if8.borrow);
        end
        n_cmp++;
        if ({if1.in_ready, if1.out_valid, if1.busy, if1.difference, if1.borrow} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_w1: rdy/vld/busy/diff/brw=%b/%b/%b/%b/%b required 1/0/0/0/0",
                     if1.in_ready, if1.out_valid, if1.busy, if1.difference, if1.borrow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_subtractor;
        for (int i = 0; i < 8; i++) begin
            int r;
            logic [2:0] v;
            v      = 3'(i);
            fs_a   = v[2];
            fs_b   = v[1];
            fs_bin = v[0];
            #1;
            r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
            n_cmp++;
            if (fs_d !== r[0] || fs_bo !== (r < 0)) begin
                n_fail++;
                $display("FAIL full_sub a=%b b=%b bin=%b: d/bo=%b/%b required %b/%b",
                         fs_a, fs_b, fs_bin, fs_d, fs_bo, r[0], (r < 0));
            end
        end
    endtask

    task automatic test_basic;
        int acc, t;
        bit ok;
        exp_t e;
        if8.out_ready = 1'b1;
        issue8(8'd200, 8'd100, acc, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_accept: timeout waiting for in_ready");
        end
        n_cmp++;
        if (if8.busy !== 1'b1 || if8.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: busy/in_ready=%b/%b required 1/0", if8.busy, if8.in_ready);
        end
        wait_out8(t, ok);
        n_cmp++;
        if (!ok || (t - acc) !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: %0d cycles (ok=%0d) required 8", t - acc, ok);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (if8.difference !== e.dif || if8.borrow !== e.brw) begin
                n_fail++;
                $display("FAIL basic_result: %0d/%b required %0d/%b", if8.difference, if8.borrow, e.dif, e.brw);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_return_idle: in_ready/out_valid=%b/%b required 1/0", if8.in_ready, if8.out_valid);
        end
    endtask

    task automatic test_patterns;
        logic [7:0] ta[8];
        logic [7:0] tb[8];
        int acc, t;
        bit ok;
        exp_t e;
        ta = '{8'd5, 8'd0, 8'd255, 8'd37, 8'd128, 8'd0, 8'd0, 8'd0};
        tb = '{8'd10, 8'd0, 8'd255, 8'd200, 8'd128, 8'd0, 8'd0, 8'd0};
        for (int i = 5; i < 8; i++) begin
            ta[i] = 8'($urandom_range(0, 255));
            tb[i] = 8'($urandom_range(0, 255));
        end
        if8.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue8(ta[i], tb[i], acc, ok);
            wait_out8(t, ok);
            n_cmp++;
            if (!ok || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pattern_%0d: no result (ok=%0d queue=%0d) required one", i, ok, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if (if8.difference !== e.dif || if8.borrow !== e.brw) begin
                    n_fail++;
                    $display("FAIL pattern_%0d A=%0d B=%0d: %0d/%b required %0d/%b",
                             i, ta[i], tb[i], if8.difference, if8.borrow, e.dif, e.brw);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        int acc, t;
        bit ok;
        exp_t e;
        if8.out_ready = 1'b0;
        issue8(8'd0, 8'd1, acc, ok);
        wait_out8(t, ok);
        n_cmp++;
        if (!ok || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL bp_result: no result (ok=%0d) required one", ok);
        end else begin
            e = exp_q.pop_front();
            if (if8.difference !== e.dif || if8.borrow !== e.brw) begin
                n_fail++;
                $display("FAIL bp_result: %0d/%b required %0d/%b", if8.difference, if8.borrow, e.dif, e.brw);
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (if8.out_valid !== 1'b1 || if8.difference !== 8'd255 || if8.borrow !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: vld/diff/brw=%b/%0d/%b required 1/255/1",
                         i, if8.out_valid, if8.difference, if8.borrow);
            end
        end
        if8.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if8.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: rdy/vld/busy=%b/%b/%b required 1/0/0", if8.in_ready, if8.out_valid, if8.busy);
        end
        n_cmp++;
        if (if8.difference !== 8'd255 || if8.borrow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_retain: %0d/%b required 255/1", if8.difference, if8.borrow);
        end
    endtask

    task automatic test_back_to_back;
        int t1, t2, outs, viol;
        bit ok, drop;
        exp_t e;
        t1 = -1; t2 = -1; outs = 0; viol = 0; ok = 1'b0; drop = 1'b0;
        if8.out_ready  = 1'b1;
        if8.in_valid   = 1'b1;
        if8.minuend    = 8'd100;
        if8.subtrahend = 8'd1;
        for (int i = 0; i < 50; i++) begin
            if (if8.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        exp_q.push_back(model8(8'd100, 8'd1));
        @(posedge clk);
        #1;
        t1 = cyc;
        if8.minuend    = 8'd3;
        if8.subtrahend = 8'd4;
        exp_q.push_back(model8(8'd3, 8'd4));
        for (int i = 0; i < 60 && outs < 2; i++) begin
            @(negedge clk);
            if (drop) begin
                if8.in_valid   = 1'b0;
                if8.minuend    = 8'hFF;
                if8.subtrahend = 8'h00;
            end
            if (if8.busy === 1'b1 && if8.in_ready === 1'b1) viol++;
            if (if8.in_valid === 1'b1 && if8.in_ready === 1'b1 && t2 < 0) begin
                t2   = cyc + 1;
                drop = 1'b1;
            end
            if (if8.out_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_result_%0d: unexpected result %0d/%b", outs, if8.difference, if8.borrow);
                end else begin
                    e = exp_q.pop_front();
                    if (if8.difference !== e.dif || if8.borrow !== e.brw) begin
                        n_fail++;
                        $display("FAIL b2b_result_%0d: %0d/%b required %0d/%b",
                                 outs, if8.difference, if8.borrow, e.dif, e.brw);
                    end
                end
                outs++;
            end
        end
        if8.in_valid = 1'b0;
        n_cmp++;
        if (!ok || outs !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: %0d results (accept ok=%0d) required 2", outs, ok);
        end
        n_cmp++;
        if ((t2 - t1) !== 10) begin
            n_fail++;
            $display("FAIL b2b_period: %0d cycles required 10", t2 - t1);
        end
        n_cmp++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL b2b_ready_while_busy: %0d cycles required 0", viol);
        end
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        int acc, t, rel;
        bit ok;
        exp_t e;
        if8.out_ready = 1'b1;
        issue8(8'hAA, 8'h11, acc, ok);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (if8.out_valid !== 1'b0 || if8.busy !== 1'b0 || if8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_state: vld/busy/rdy=%b/%b/%b required 0/0/1", if8.out_valid, if8.busy, if8.in_ready);
        end
        n_cmp++;
        if (if8.difference !== 8'd0 || if8.borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_outputs: %0d/%b required 0/0", if8.difference, if8.borrow);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        issue8(8'd9, 8'd3, acc, ok);
        n_cmp++;
        if (!ok || acc !== rel + 1) begin
            n_fail++;
            $display("FAIL areset_first_accept: edge %0d (ok=%0d) required %0d", acc, ok, rel + 1);
        end
        wait_out8(t, ok);
        n_cmp++;
        if (!ok || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL areset_result: no result (ok=%0d) required 6/0", ok);
        end else begin
            e = exp_q.pop_front();
            if (if8.difference !== e.dif || if8.borrow !== e.brw || (t - acc) !== 8) begin
                n_fail++;
                $display("FAIL areset_result: %0d/%b after %0d cycles required %0d/%b after 8",
                         if8.difference, if8.borrow, t - acc, e.dif, e.brw);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_width1;
        int acc, t;
        bit ok;
        logic a, b;
        logic [1:0] tt, e;
        if1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tt = 2'(i);
            a  = tt[1];
            b  = tt[0];
            ok = 1'b0;
            t  = -1;
            if1.in_valid   = 1'b1;
            if1.minuend    = a;
            if1.subtrahend = b;
            for (int k = 0; k < 20; k++) begin
                if (if1.in_ready === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            exp1_q.push_back({1'b0, a} - {1'b0, b});
            @(posedge clk);
            #1;
            acc = cyc;
            if1.in_valid = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (if1.out_valid === 1'b1) begin
                    t = cyc;
                    break;
                end
            end
            e = exp1_q.pop_front();
            n_cmp++;
            if (!ok || (t - acc) !== 1 || if1.difference !== e[0] || if1.borrow !== e[1]) begin
                n_fail++;
                $display("FAIL w1_A%0d_B%0d: %b/%b after %0d cycles required %b/%b after 1",
                         a, b, if1.difference, if1.borrow, t - acc, e[0], e[1]);
            end
            if (a == 1'b0 && b == 1'b1) begin
                n_cmp++;
                if (if1.difference !== 1'b1 || if1.borrow !== 1'b1) begin
                    n_fail++;
                    $display("FAIL w1_underflow: %b/%b required 1/1", if1.difference, if1.borrow);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_full_subtractor();
        test_basic();
        test_patterns();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_width1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
